id_exe_stage: RTL and testbench
===============================

# id_exe_stage

Parametrised ID/EX pipeline register for the 32-bit MIPS core, sitting between decode and execute. Adds what a plain ID/EX latch lacks:
- valid bit;
- downstream stall (hold);
- flush (kill);
- built-in load-use hazard detection that inserts a bubble and tells IF/ID to hold;
- saturating bubble counter for performance monitoring.

## Interface
Parameters:
- PC_W, 7, width of pc field
- DATA_W, 32, width of readData1/readData2/sign_extended
- REG_W, 5, register specifier width
- WB_W, 2, WB control bundle width
- MEM_W, 3, MEM control bundle width
- EXE_W, 3, EXE control bundle width
- MEMREAD_BIT, 2, index in MEM bundle that marks a load
- CNT_W, 16, bubble counter width

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- idValid  in  1  decode stage holds a real instruction
- pc  in  PC_W  decode pc
- readData1, readData2  in  DATA_W  register file operands
- sign_extended  in  DATA_W  extended immediate
- rs, rt, rd  in  REG_W  decoded register specifiers
- WB  in  WB_W  writeback controls
- MEM  in  MEM_W  memory controls
- EXE  in  EXE_W  execute controls
- stall  in  1  execute/downstream not accepting; hold register
- flush  in  1  kill instruction entering this stage (branch/exception)
- validOut  out  1  EX stage holds a real instruction
- pcOut, readData1Out, readData2Out, sign_extendedOut, rsOut, rtOut, rdOut, WBOut, MEMOut, EXEOut  out  matching widths  registered copies
- hazardStall  out  1  combinational: IF/ID must hold this cycle
- bubbleCount  out  CNT_W  number of hazard bubbles inserted, saturating

## Operation
- loadUse = validOut & MEMOut[MEMREAD_BIT] & (rtOut != 0) & idValid & (rtOut == rs | rtOut == rt).
- hazardStall = loadUse & !stall & !flush.
- Per rising edge, first match wins:
  1. flush: validOut←0, WBOut/MEMOut/EXEOut←0; data fields don't-care, implemented as load.
  2. stall: all registers hold, including validOut.
  3. loadUse: bubble. validOut←0, WBOut/MEMOut/EXEOut←0, data fields hold. bubbleCount increments unless at 2^CNT_W−1.
  4. Otherwise load all fields from inputs. validOut←idValid; controls forced to 0 when idValid=0.
- Invariant: validOut=0 implies WBOut, MEMOut, EXEOut all 0, so a bubble never writes the register file or memory.
- After a bubble, the load has moved to MEM. The same ID instruction is presented again (IF/ID held) and loads normally.
- bubbleCount changes only on case 3. Flush and stall never increment it.
- Register 0 as load destination never causes a hazard.

## Timing
- Latency: 1 cycle, input to output, on the next rising edge when loading.
- hazardStall is purely combinational from current register state and inputs, valid in the same cycle. Exactly one bubble per load-use pair.
- Reset: asynchronous assert on reset_n low, synchronous-safe release. All outputs go to 0: validOut, all data/specifier fields, all control bundles, bubbleCount. hazardStall is therefore 0.
- Reset mid-operation clears any pending hazard and the counter immediately, without waiting for a clock edge.
- Simultaneous events:
  - flush+stall: flush wins.
  - stall+loadUse: hold, no bubble, hazardStall=0, since IF/ID is held by stall anyway.
  - flush+loadUse: flush, no count.

## Test plan
- Reset: drive reset_n=0 mid-cycle with nonzero registers -> all outputs 0 before next edge; bubbleCount=0.
- Normal flow: idValid=1, pc=7'h04, readData1=32'h11, rt=5, WB=2'b10 -> next edge validOut=1 with identical values; 3 back-to-back instructions emerge in order, one per cycle.
- Load-use: EX holds load (MEM[2]=1, rtOut=8, validOut=1); ID presents rs=8 -> hazardStall=1 that cycle; next edge validOut=0, controls 0, bubbleCount=1; following edge the held ID instruction loads with validOut=1. Repeat with rtOut=0 -> no hazard.
- Stall hold: load an instruction, assert stall 3 cycles while changing inputs -> outputs unchanged; deassert -> current inputs load next edge.
- Priority: flush+stall -> validOut=0, controls 0. stall+loadUse -> hold, hazardStall=0, count unchanged. flush+loadUse -> validOut=0, count unchanged.
- Counter saturation: CNT_W=2, force 5 load-use bubbles -> bubbleCount stops at 3.

Source files
------------

// File: rtl/id_exe_stage.sv
// ID/EX pipeline register with valid bit, stall/flush handling, load-use
// bubble insertion and a saturating bubble counter.
module id_exe_stage #(
    parameter int PC_W        = 7,
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5,
    parameter int WB_W        = 2,
    parameter int MEM_W       = 3,
    parameter int EXE_W       = 3,
    parameter int MEMREAD_BIT = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              idValid,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] readData1,
    input  logic [DATA_W-1:0] readData2,
    input  logic [DATA_W-1:0] sign_extended,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    input  logic [REG_W-1:0]  rd,
    input  logic [WB_W-1:0]   WB,
    input  logic [MEM_W-1:0]  MEM,
    input  logic [EXE_W-1:0]  EXE,
    input  logic              stall,
    input  logic              flush,
    output logic              validOut,
    output logic [PC_W-1:0]   pcOut,
    output logic [DATA_W-1:0] readData1Out,
    output logic [DATA_W-1:0] readData2Out,
    output logic [DATA_W-1:0] sign_extendedOut,
    output logic [REG_W-1:0]  rsOut,
    output logic [REG_W-1:0]  rtOut,
    output logic [REG_W-1:0]  rdOut,
    output logic [WB_W-1:0]   WBOut,
    output logic [MEM_W-1:0]  MEMOut,
    output logic [EXE_W-1:0]  EXEOut,
    output logic              hazardStall,
    output logic [CNT_W-1:0]  bubbleCount
);

    logic loadUse;

    // A load in EX whose destination (never $zero) is read by the instruction in ID.
    assign loadUse = validOut & MEMOut[MEMREAD_BIT] & (rtOut != '0) & idValid &
                     ((rtOut == rs) | (rtOut == rt));

    assign hazardStall = loadUse & ~stall & ~flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            validOut         <= 1'b0;
            pcOut            <= '0;
            readData1Out     <= '0;
            readData2Out     <= '0;
            sign_extendedOut <= '0;
            rsOut            <= '0;
            rtOut            <= '0;
            rdOut            <= '0;
            WBOut            <= '0;
            MEMOut           <= '0;
            EXEOut           <= '0;
            bubbleCount      <= '0;
        end else if (flush) begin
            validOut         <= 1'b0;
            pcOut            <= pc;
            readData1Out     <= readData1;
            readData2Out     <= readData2;
            sign_extendedOut <= sign_extended;
            rsOut            <= rs;
            rtOut            <= rt;
            rdOut            <= rd;
            WBOut            <= '0;
            MEMOut           <= '0;
            EXEOut           <= '0;
        end else if (stall) begin
            validOut <= validOut;
        end else if (loadUse) begin
            // Bubble: data fields hold, controls cleared so nothing gets written.
            validOut <= 1'b0;
            WBOut    <= '0;
            MEMOut   <= '0;
            EXEOut   <= '0;
            if (bubbleCount != '1)
                bubbleCount <= bubbleCount + 1'b1;
        end else begin
            validOut         <= idValid;
            pcOut            <= pc;
            readData1Out     <= readData1;
            readData2Out     <= readData2;
            sign_extendedOut <= sign_extended;
            rsOut            <= rs;
            rtOut            <= rt;
            rdOut            <= rd;
            WBOut            <= idValid ? WB  : '0;
            MEMOut           <= idValid ? MEM : '0;
            EXEOut           <= idValid ? EXE : '0;
        end
    end

endmodule

// File: tb/tb_id_exe_stage.sv
// Directed bench for id_exe_stage: reset, flow, load-use, stall, priority
// and counter saturation (second instance with a 2-bit counter).
module tb_id_exe_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        idValid;
    logic [6:0]  pc;
    logic [31:0] readData1, readData2, sign_extended;
    logic [4:0]  rs, rt, rd;
    logic [1:0]  WB;
    logic [2:0]  MEM, EXE;
    logic        stall, flush;

    logic        validOut, hazardStall;
    logic [6:0]  pcOut;
    logic [31:0] readData1Out, readData2Out, sign_extendedOut;
    logic [4:0]  rsOut, rtOut, rdOut;
    logic [1:0]  WBOut;
    logic [2:0]  MEMOut, EXEOut;
    logic [15:0] bubbleCount;

    logic        bValidOut, bHazardStall;
    logic [6:0]  bPcOut;
    logic [31:0] bReadData1Out, bReadData2Out, bSignExtendedOut;
    logic [4:0]  bRsOut, bRtOut, bRdOut;
    logic [1:0]  bWBOut;
    logic [2:0]  bMEMOut, bEXEOut;
    logic [1:0]  bBubbleCount;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clock = ~clock;

    id_exe_stage dut (
        .clock(clock), .reset_n(reset_n), .idValid(idValid), .pc(pc),
        .readData1(readData1), .readData2(readData2), .sign_extended(sign_extended),
        .rs(rs), .rt(rt), .rd(rd), .WB(WB), .MEM(MEM), .EXE(EXE),
        .stall(stall), .flush(flush), .validOut(validOut), .pcOut(pcOut),
        .readData1Out(readData1Out), .readData2Out(readData2Out),
        .sign_extendedOut(sign_extendedOut), .rsOut(rsOut), .rtOut(rtOut),
        .rdOut(rdOut), .WBOut(WBOut), .MEMOut(MEMOut), .EXEOut(EXEOut),
        .hazardStall(hazardStall), .bubbleCount(bubbleCount)
    );

    id_exe_stage #(.CNT_W(2)) dutSat (
        .clock(clock), .reset_n(reset_n), .idValid(idValid), .pc(pc),
        .readData1(readData1), .readData2(readData2), .sign_extended(sign_extended),
        .rs(rs), .rt(rt), .rd(rd), .WB(WB), .MEM(MEM), .EXE(EXE),
        .stall(stall), .flush(flush), .validOut(bValidOut), .pcOut(bPcOut),
        .readData1Out(bReadData1Out), .readData2Out(bReadData2Out),
        .sign_extendedOut(bSignExtendedOut), .rsOut(bRsOut), .rtOut(bRtOut),
        .rdOut(bRdOut), .WBOut(bWBOut), .MEMOut(bMEMOut), .EXEOut(bEXEOut),
        .hazardStall(bHazardStall), .bubbleCount(bBubbleCount)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [6:0] p, input logic [4:0] s,
                                 input logic [4:0] t, input logic [1:0] w,
                                 input logic [2:0] m, input logic [2:0] e);
        idValid = v; pc = p; rs = s; rt = t; rd = t + 5'd1; WB = w; MEM = m; EXE = e;
        readData1 = {25'd0, p} + 32'h100;
        readData2 = {25'd0, p} + 32'h200;
        sign_extended = {25'd0, p} + 32'h300;
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
        applyStimulus(1'b0, 7'h00, 5'd0, 5'd0, 2'b00, 3'b000, 3'b000);
        tick(); tick();
        #2 reset_n = 1'b1;
        #1;
        checkOutput("reset_valid", validOut, 0);
        checkOutput("reset_count", bubbleCount, 0);
        checkOutput("reset_hazard", hazardStall, 0);

        // Normal flow
        applyStimulus(1'b1, 7'h04, 5'd1, 5'd5, 2'b10, 3'b000, 3'b001);
        readData1 = 32'h11;
        tick();
        checkOutput("flow_valid", validOut, 1);
        checkOutput("flow_pc", pcOut, 7'h04);
        checkOutput("flow_rd1", readData1Out, 32'h11);
        checkOutput("flow_rt", rtOut, 5'd5);
        checkOutput("flow_rd", rdOut, 5'd6);
        checkOutput("flow_wb", WBOut, 2'b10);
        checkOutput("flow_exe", EXEOut, 3'b001);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 7'(4 + 4 * i), 5'd2, 5'(5 + i), 2'b01, 3'b001, 3'b010);
            tick();
            checkOutput("b2b_pc", pcOut, 64'(4 + 4 * i));
            checkOutput("b2b_rd2", readData2Out, 64'(32'h200 + 4 + 4 * i));
            checkOutput("b2b_mem", MEMOut, 3'b001);
        end

        // Load-use: load to $8, then consumer reading $8 via rs
        applyStimulus(1'b1, 7'h20, 5'd1, 5'd8, 2'b11, 3'b100, 3'b000);
        tick();
        applyStimulus(1'b1, 7'h24, 5'd8, 5'd9, 2'b10, 3'b000, 3'b010);
        #1;
        checkOutput("lu_hazard", hazardStall, 1);
        tick();
        checkOutput("lu_bubble_valid", validOut, 0);
        checkOutput("lu_bubble_wb", WBOut, 0);
        checkOutput("lu_bubble_mem", MEMOut, 0);
        checkOutput("lu_bubble_exe", EXEOut, 0);
        checkOutput("lu_count", bubbleCount, 1);
        checkOutput("lu_pc_held", pcOut, 7'h20);
        checkOutput("lu_hazard_gone", hazardStall, 0);
        tick();
        checkOutput("lu_reload_valid", validOut, 1);
        checkOutput("lu_reload_pc", pcOut, 7'h24);
        checkOutput("lu_reload_wb", WBOut, 2'b10);
        checkOutput("lu_count_stable", bubbleCount, 1);

        // Load to $zero never creates a hazard
        applyStimulus(1'b1, 7'h28, 5'd1, 5'd0, 2'b11, 3'b100, 3'b000);
        tick();
        applyStimulus(1'b1, 7'h2c, 5'd0, 5'd0, 2'b10, 3'b000, 3'b000);
        #1;
        checkOutput("r0_hazard", hazardStall, 0);
        tick();
        checkOutput("r0_valid", validOut, 1);
        checkOutput("r0_pc", pcOut, 7'h2c);
        checkOutput("r0_count", bubbleCount, 1);

        // Invalid ID slot: no hazard, controls forced to zero
        applyStimulus(1'b1, 7'h2e, 5'd1, 5'd8, 2'b11, 3'b100, 3'b000);
        tick();
        applyStimulus(1'b0, 7'h2f, 5'd8, 5'd8, 2'b11, 3'b111, 3'b111);
        #1;
        checkOutput("inv_hazard", hazardStall, 0);
        tick();
        checkOutput("inv_valid", validOut, 0);
        checkOutput("inv_wb", WBOut, 0);
        checkOutput("inv_mem", MEMOut, 0);

        // Stall holds for three cycles while inputs change
        applyStimulus(1'b1, 7'h30, 5'd1, 5'd3, 2'b01, 3'b001, 3'b011);
        readData2 = 32'hABCD;
        tick();
        stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 7'(8'h30 + i), 5'd4, 5'd4, 2'b10, 3'b010, 3'b100);
            readData2 = 32'h1234 + i;
            tick();
            checkOutput("stall_pc", pcOut, 7'h30);
            checkOutput("stall_rd2", readData2Out, 32'hABCD);
            checkOutput("stall_valid", validOut, 1);
            checkOutput("stall_exe", EXEOut, 3'b011);
        end
        stall = 1'b0;
        applyStimulus(1'b1, 7'h33, 5'd4, 5'd4, 2'b10, 3'b000, 3'b100);
        readData2 = 32'h5555;
        tick();
        checkOutput("unstall_pc", pcOut, 7'h33);
        checkOutput("unstall_rd2", readData2Out, 32'h5555);

        // flush + stall: flush wins
        stall = 1'b1; flush = 1'b1;
        applyStimulus(1'b1, 7'h40, 5'd1, 5'd2, 2'b11, 3'b011, 3'b111);
        tick();
        checkOutput("fs_valid", validOut, 0);
        checkOutput("fs_wb", WBOut, 0);
        checkOutput("fs_mem", MEMOut, 0);
        checkOutput("fs_exe", EXEOut, 0);
        stall = 1'b0; flush = 1'b0;

        // stall + loadUse: hold, no bubble
        applyStimulus(1'b1, 7'h50, 5'd1, 5'd10, 2'b11, 3'b100, 3'b000);
        tick();
        applyStimulus(1'b1, 7'h54, 5'd10, 5'd2, 2'b10, 3'b000, 3'b000);
        stall = 1'b1;
        #1;
        checkOutput("sl_hazard", hazardStall, 0);
        tick();
        checkOutput("sl_valid", validOut, 1);
        checkOutput("sl_pc", pcOut, 7'h50);
        checkOutput("sl_mem", MEMOut, 3'b100);
        checkOutput("sl_count", bubbleCount, 1);

        // flush + loadUse: flush, no count
        stall = 1'b0; flush = 1'b1;
        #1;
        checkOutput("fl_hazard", hazardStall, 0);
        tick();
        checkOutput("fl_valid", validOut, 0);
        checkOutput("fl_mem", MEMOut, 0);
        checkOutput("fl_count", bubbleCount, 1);
        flush = 1'b0;

        // Asynchronous reset mid-cycle with a pending hazard
        applyStimulus(1'b1, 7'h60, 5'd1, 5'd7, 2'b11, 3'b100, 3'b001);
        tick();
        applyStimulus(1'b1, 7'h64, 5'd7, 5'd1, 2'b10, 3'b000, 3'b000);
        #1;
        checkOutput("ar_hazard_before", hazardStall, 1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("ar_valid", validOut, 0);
        checkOutput("ar_pc", pcOut, 0);
        checkOutput("ar_rt", rtOut, 0);
        checkOutput("ar_mem", MEMOut, 0);
        checkOutput("ar_hazard", hazardStall, 0);
        checkOutput("ar_count", bubbleCount, 0);
        checkOutput("ar_sat_count", bBubbleCount, 0);
        #1 reset_n = 1'b1;

        // Five bubbles: 16-bit counter reaches 5, 2-bit counter stops at 3
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 7'h70, 5'd1, 5'd8, 2'b11, 3'b100, 3'b000);
            tick();
            applyStimulus(1'b1, 7'h74, 5'd2, 5'd8, 2'b10, 3'b000, 3'b000);
            tick();
            checkOutput("sat_bubble_valid", bValidOut, 0);
            checkOutput("sat_count_wide", bubbleCount, 64'(i));
            checkOutput("sat_count_narrow", bBubbleCount, 64'((i > 3) ? 3 : i));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
